// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC generator and IF/ID capture stage.
// It drives a zero-latency instruction memory read port from pc_q and captures
// the returned word into the IF/ID register. It supports stall, redirect with
// wrong-path flush, and a sticky fault on an invalid fetch address.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        imem_inv_addr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic        if_id_valid,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        halted,
  output logic [63:0] fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t      state;
  logic [63:0] pc_q;

  // The memory read port is combinational, so the fetch address is pc_q itself.
  assign imem_pc = pc_q;

  // Sequencer state, PC and IF/ID register, updated in one place so that the
  // RUN-state priority (redirect > stall > fault > fetch) is explicit.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments, so every branch reads
    // pre-edge values (e.g. fault_pc <= pc_q captures the PC that faulted).
    if (!rst_n) begin
      state       <= RUN;
      pc_q        <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
      halted      <= 1'b0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (redirect_valid) begin
            // The instruction in IF/ID is wrong-path; drop it and refetch.
            pc_q        <= redirect_target;
            if_id_valid <= 1'b0;
          end else if (stall) begin
            // Hold everything. An invalid address is not acted on while stalled.
          end else if (imem_inv_addr) begin
            state       <= FAULT;
            halted      <= 1'b1;
            fault_pc    <= pc_q;
            if_id_valid <= 1'b0;
          end else begin
            if_id_valid <= 1'b1;
            if_id_pc    <= pc_q;
            if_id_instr <= imem_instr;
            pc_q        <= pc_q + 64'(PC_STEP);
            fetch_count <= fetch_count + 32'd1;
          end
        end
        FAULT: begin
          // Sticky until reset; redirect and stall are ignored.
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. A behavioural model of the sequencer
// and of a 4 KiB instruction memory (plus a small valid window at the top of
// the 64-bit address space, so PC wrap can be exercised) is checked against the
// DUT every cycle. Directed literal checks pin the model to the test plan.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [63:0] imem_pc;
  logic [31:0] imem_instr;
  logic        imem_inv_addr;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        halted;
  logic [63:0] fault_pc;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  fetch_sequencer #(.RESET_PC(64'h0), .PC_STEP(4)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_pc         (imem_pc),
    .imem_instr      (imem_instr),
    .imem_inv_addr   (imem_inv_addr),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .halted          (halted),
    .fault_pc        (fault_pc),
    .fetch_count     (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- instruction memory model ----------------
  logic [31:0] mem [0:1023];

  function automatic logic addr_bad(input logic [63:0] a);
    logic hi_window;
    hi_window = (a >= 64'hFFFF_FFFF_FFFF_FFF0);
    return (a[1:0] != 2'b00) || !((a < 64'h1000) || hi_window);
  endfunction

  function automatic logic [31:0] word_at(input logic [63:0] a);
    if (addr_bad(a)) return 32'hDEAD_BEEF;
    if (a < 64'h1000) return mem[a[11:2]];
    return ~a[31:0];
  endfunction

  assign imem_inv_addr = addr_bad(imem_pc);
  assign imem_instr    = word_at(imem_pc);

  // ---------------- behavioural sequencer model ----------------
  logic [63:0] m_pc;
  logic        m_valid;
  logic [63:0] m_if_pc;
  logic [31:0] m_if_instr;
  logic        m_halted;
  logic [63:0] m_fault_pc;
  logic [31:0] m_count;
  logic        m_known = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 64'h0; m_valid = 1'b0; m_if_pc = '0; m_if_instr = '0;
      m_halted = 1'b0; m_fault_pc = '0; m_count = '0; m_known = 1'b1;
    end else if (m_known && !m_halted) begin
      if (redirect_valid) begin
        m_pc = redirect_target;
        m_valid = 1'b0;
      end else if (stall) begin
        // nothing moves
      end else if (addr_bad(m_pc)) begin
        m_halted = 1'b1;
        m_fault_pc = m_pc;
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
        m_if_pc = m_pc;
        m_if_instr = word_at(m_pc);
        m_pc = m_pc + 64'd4;
        m_count = m_count + 32'd1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      check("imem_pc",     imem_pc,             m_pc);
      check("if_id_valid", 64'(if_id_valid),    64'(m_valid));
      check("halted",      64'(halted),         64'(m_halted));
      check("fault_pc",    fault_pc,            m_fault_pc);
      check("fetch_count", 64'(fetch_count),    64'(m_count));
      check("if_id_pc",    if_id_pc,            m_if_pc);
      check("if_id_instr", 64'(if_id_instr),    64'(m_if_instr));
    end
  end

  // Apply one cycle of inputs; returns just after the following negedge.
  task automatic step(input logic r, input logic s, input logic rv, input logic [63:0] t);
    rst_n = r; stall = s; redirect_valid = rv; redirect_target = t;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h0055_0533;
    mem[1] = 32'h40b5_0533;
    mem[2] = 32'h00c5_7533;
    mem[3] = 32'h00E5_6FB3;
    mem[6] = 32'h00B2_82B3;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("rst halted",  64'(halted),      64'd0);
    check("rst pc",      imem_pc,          64'h0);
    check("rst count",   64'(fetch_count), 64'd0);
    check("rst valid",   64'(if_id_valid), 64'd0);

    // Four free-running fetches.
    run(4);
    check("seq if_pc",  if_id_pc,          64'hC);
    check("seq instr",  64'(if_id_instr),  64'h00E5_6FB3);
    check("seq count",  64'(fetch_count),  64'd4);
    check("seq pc",     imem_pc,           64'h10);

    // Stall three cycles at pc_q=8.
    step(1'b0, 1'b0, 1'b0, 64'h0);
    run(2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 64'h0);
    check("stall pc",    imem_pc,          64'h8);
    check("stall if_pc", if_id_pc,         64'h4);
    check("stall instr", 64'(if_id_instr), 64'h40b5_0533);
    check("stall count", 64'(fetch_count), 64'd2);
    run(1);
    check("resume if_pc", if_id_pc,        64'h8);

    // Redirect together with stall at pc_q=0xC.
    step(1'b1, 1'b1, 1'b1, 64'h18);
    check("redir pc",    imem_pc,          64'h18);
    check("redir valid", 64'(if_id_valid), 64'd0);
    run(1);
    check("redir if_pc", if_id_pc,         64'h18);
    check("redir instr", 64'(if_id_instr), 64'h00B2_82B3);

    // Misaligned redirect leads to a fault; later redirects are ignored.
    step(1'b1, 1'b0, 1'b1, 64'h6);
    run(1);
    check("mis halted",  64'(halted),      64'd1);
    check("mis fault",   fault_pc,         64'h6);
    check("mis valid",   64'(if_id_valid), 64'd0);
    step(1'b1, 1'b0, 1'b1, 64'h100);
    step(1'b1, 1'b1, 1'b1, 64'h200);
    check("fault hold pc", imem_pc,        64'h6);

    // One-cycle reset out of FAULT.
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("unf halted",  64'(halted),      64'd0);
    check("unf pc",      imem_pc,          64'h0);
    check("unf count",   64'(fetch_count), 64'd0);
    run(1);
    check("unf fetch",   64'(fetch_count), 64'd1);

    // End of memory.
    step(1'b1, 1'b0, 1'b1, 64'hFF8);
    run(2);
    check("eom if_pc",   if_id_pc,         64'hFFC);
    check("eom pc",      imem_pc,          64'h1000);
    run(1);
    check("eom halted",  64'(halted),      64'd1);
    check("eom fault",   fault_pc,         64'h1000);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    run(3);
    check("wrap if_pc",  if_id_pc,         64'h0);
    check("wrap pc",     imem_pc,          64'h4);
    check("wrap halted", 64'(halted),      64'd0);

    // Randomized traffic checked against the model.
    for (int i = 0; i < 4000; i++) begin
      logic        r, s, rv;
      logic [63:0] t;
      int          sel;
      r   = ($urandom_range(0, 199) != 0) && !(m_halted && $urandom_range(0, 9) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 7)       t = {52'h0, 10'($urandom), 2'b00};
      else if (sel == 7) t = {52'h0, 12'($urandom) | 12'h1};
      else if (sel == 8) t = 64'h1000 + 64'($urandom_range(0, 255) * 4);
      else               t = {60'hFFFF_FFFF_FFFF_FFF, 2'($urandom), 2'b00};
      step(r, s, rv, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
